// File: rtl/alu_exec_seq_pkg.sv
// Shared definitions for the ALU issue/sequencing stage: opcodes, flag bit
// positions and FSM state encoding.
package alu_exec_seq_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_INC  = 4'b0010;
  localparam logic [3:0] OP_DEC  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_NOT  = 4'b0111;
  localparam logic [3:0] OP_SHL  = 4'b1000;
  localparam logic [3:0] OP_SHR  = 4'b1001;
  localparam logic [3:0] OP_ROL  = 4'b1010;
  localparam logic [3:0] OP_ROR  = 4'b1011;
  localparam logic [3:0] OP_NAND = 4'b1100;
  localparam logic [3:0] OP_NOR  = 4'b1101;
  localparam logic [3:0] OP_GT   = 4'b1110;
  localparam logic [3:0] OP_LE   = 4'b1111;

  localparam int FLG_COUT  = 0;
  localparam int FLG_ZERO  = 1;
  localparam int FLG_OVF   = 2;
  localparam int FLG_NEG   = 3;
  localparam int FLG_EQUAL = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/alu_exec_seq_if.sv
// Command, response, ALU-side and status signals of the issue stage.
// The slave modport is the issue stage; the master modport is its surroundings.
interface alu_exec_seq_if #(
  parameter int N   = 8,
  parameter int RAW = 2
) ();

  logic           cmd_valid;
  logic           cmd_ready;
  logic [3:0]     cmd_op;
  logic [RAW-1:0] cmd_rd;
  logic [RAW-1:0] cmd_ra;
  logic [RAW-1:0] cmd_rb;
  logic           cmd_a_zero;
  logic           cmd_use_imm;
  logic [N-1:0]   cmd_imm;

  logic [N-1:0]   alu_a;
  logic [N-1:0]   alu_b;
  logic [3:0]     alu_sel;
  logic [N-1:0]   alu_result;
  logic           alu_cout;
  logic           alu_zero;
  logic           alu_ovf;
  logic           alu_neg;
  logic           alu_equal;

  logic           rsp_valid;
  logic           rsp_ready;
  logic [N-1:0]   rsp_data;
  logic [RAW-1:0] rsp_rd;
  logic [4:0]     rsp_flags;

  logic [4:0]     sticky_flags;
  logic           sticky_clr;

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_a_zero, cmd_use_imm, cmd_imm,
    output cmd_ready,
    output alu_a, alu_b, alu_sel,
    input  alu_result, alu_cout, alu_zero, alu_ovf, alu_neg, alu_equal,
    output rsp_valid, rsp_data, rsp_rd, rsp_flags,
    input  rsp_ready,
    output sticky_flags,
    input  sticky_clr
  );

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_a_zero, cmd_use_imm, cmd_imm,
    input  cmd_ready,
    input  alu_a, alu_b, alu_sel,
    output alu_result, alu_cout, alu_zero, alu_ovf, alu_neg, alu_equal,
    input  rsp_valid, rsp_data, rsp_rd, rsp_flags,
    output rsp_ready,
    input  sticky_flags,
    output sticky_clr
  );

endinterface

// File: rtl/alu_exec_seq_regfile.sv
// General register file for the issue stage: NREG x N, two asynchronous
// read ports, one synchronous write port, cleared by reset.
module alu_exec_regfile #(
  parameter int N    = 8,
  parameter int NREG = 4,
  parameter int RAW  = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [RAW-1:0] rd_addr_a,
  input  logic [RAW-1:0] rd_addr_b,
  output logic [N-1:0]   rd_data_a,
  output logic [N-1:0]   rd_data_b,
  input  logic           wr_en,
  input  logic [RAW-1:0] wr_addr,
  input  logic [N-1:0]   wr_data
);

  logic [N-1:0] mem [NREG];

  assign rd_data_a = mem[rd_addr_a];
  assign rd_data_b = mem[rd_addr_b];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/alu_exec_seq.sv
// Issue/sequencing stage in front of the combinational ALU: reads operands,
// drives the ALU for one cycle, writes back and returns the result with flags.
module alu_exec_seq
  import alu_exec_seq_pkg::*;
#(
  parameter int N    = 8,
  parameter int NREG = 4,
  parameter int RAW  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_exec_seq_if.slave   bus
);

  logic [1:0]     state;
  logic [RAW-1:0] rd_q;
  logic [N-1:0]   reg_a_data;
  logic [N-1:0]   reg_b_data;
  logic [4:0]     alu_flags;
  logic           wr_en;

  assign bus.cmd_ready = (state == ST_IDLE);
  assign bus.rsp_valid = (state == ST_RESP);
  assign bus.rsp_rd    = rd_q;
  assign wr_en         = (state == ST_EXEC);

  always_comb begin
    alu_flags            = '0;
    alu_flags[FLG_COUT]  = bus.alu_cout;
    alu_flags[FLG_ZERO]  = bus.alu_zero;
    alu_flags[FLG_OVF]   = bus.alu_ovf;
    alu_flags[FLG_NEG]   = bus.alu_neg;
    alu_flags[FLG_EQUAL] = bus.alu_equal;
  end

  alu_exec_regfile #(
    .N    (N),
    .NREG (NREG),
    .RAW  (RAW)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr_a (bus.cmd_ra),
    .rd_addr_b (bus.cmd_rb),
    .rd_data_a (reg_a_data),
    .rd_data_b (reg_b_data),
    .wr_en     (wr_en),
    .wr_addr   (rd_q),
    .wr_data   (bus.alu_result)
  );

  // Operands are registered at issue, so the ALU sees them for the whole EXEC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      rd_q          <= '0;
      bus.alu_a     <= '0;
      bus.alu_b     <= '0;
      bus.alu_sel   <= '0;
      bus.rsp_data  <= '0;
      bus.rsp_flags <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            bus.alu_a   <= bus.cmd_a_zero ? '0 : reg_a_data;
            bus.alu_b   <= bus.cmd_use_imm ? bus.cmd_imm : reg_b_data;
            bus.alu_sel <= bus.cmd_op;
            rd_q        <= bus.cmd_rd;
            state       <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          bus.rsp_data  <= bus.alu_result;
          bus.rsp_flags <= alu_flags;
          state         <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A clear coinciding with a capture keeps only the new op's flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.sticky_flags <= '0;
    end else if (state == ST_EXEC) begin
      bus.sticky_flags <= (bus.sticky_clr ? 5'b0 : bus.sticky_flags) | alu_flags;
    end else if (bus.sticky_clr) begin
      bus.sticky_flags <= '0;
    end
  end

endmodule

// File: tb/tb_alu_exec_seq.sv
// Directed bench for alu_exec_seq with a behavioural ALU stand-in and a
// scoreboard of expected responses built from a reference register model.
module tb_alu_exec_seq;
  import alu_exec_seq_pkg::*;

  localparam int N    = 8;
  localparam int NREG = 4;
  localparam int RAW  = 2;

  typedef struct packed {
    logic [N-1:0]   data;
    logic [RAW-1:0] rd;
    logic [4:0]     flags;
  } exp_t;

  logic clk;
  logic rst_n;

  alu_exec_seq_if #(.N(N), .RAW(RAW)) bus ();

  alu_exec_seq #(.N(N), .NREG(NREG), .RAW(RAW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t         sb_q[$];
  logic [N-1:0] regs_m [NREG];
  logic [4:0]   sticky_m;
  int           checks;
  int           passes;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {equal, neg, ovf, zero, cout, result}
  function automatic logic [N+4:0] aluModel(input logic [3:0] op, input logic [N-1:0] a,
                                            input logic [N-1:0] b);
    logic [N:0]   wide;
    logic [N-1:0] r;
    logic         c, v;
    wide = '0;
    c    = 1'b0;
    v    = 1'b0;
    case (op)
      OP_ADD: begin
        wide = {1'b0, a} + {1'b0, b};
        c    = wide[N];
        v    = (a[N-1] == b[N-1]) && (wide[N-1] != a[N-1]);
      end
      OP_SUB: begin
        wide = {1'b0, a} - {1'b0, b};
        c    = wide[N];
        v    = (a[N-1] != b[N-1]) && (wide[N-1] != a[N-1]);
      end
      default: wide = {1'b0, a};
    endcase
    r = wide[N-1:0];
    return {(a == b), r[N-1], v, (r == '0), c, r};
  endfunction

  logic [N+4:0] alu_out;
  always_comb begin
    alu_out        = aluModel(bus.alu_sel, bus.alu_a, bus.alu_b);
    bus.alu_result = alu_out[N-1:0];
    bus.alu_cout   = alu_out[N];
    bus.alu_zero   = alu_out[N+1];
    bus.alu_ovf    = alu_out[N+2];
    bus.alu_neg    = alu_out[N+3];
    bus.alu_equal  = alu_out[N+4];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic resetModel();
    for (int i = 0; i < NREG; i++) regs_m[i] = '0;
    sticky_m = '0;
    sb_q.delete();
  endtask

  // Drives a command and pushes its expected response; the caller waits for acceptance.
  task automatic applyStimulus(input logic [3:0] op, input logic [RAW-1:0] rd,
                               input logic [RAW-1:0] ra, input logic [RAW-1:0] rb,
                               input logic a_zero, input logic use_imm, input logic [N-1:0] imm);
    logic [N-1:0] a, b;
    logic [N+4:0] m;
    exp_t         e;
    bus.cmd_op      = op;
    bus.cmd_rd      = rd;
    bus.cmd_ra      = ra;
    bus.cmd_rb      = rb;
    bus.cmd_a_zero  = a_zero;
    bus.cmd_use_imm = use_imm;
    bus.cmd_imm     = imm;
    bus.cmd_valid   = 1'b1;
    a       = a_zero ? '0 : regs_m[ra];
    b       = use_imm ? imm : regs_m[rb];
    m       = aluModel(op, a, b);
    e.data  = m[N-1:0];
    e.rd    = rd;
    e.flags = m[N+4:N];
    sb_q.push_back(e);
    regs_m[rd] = m[N-1:0];
  endtask

  task automatic waitAccept();
    int w;
    for (w = 0; w < 20 && !bus.cmd_ready; w++) @(negedge clk);
    check("accept_timeout", {31'b0, (w < 20)}, 32'd1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  // Called just after the accepting edge; optionally asserts sticky_clr through EXEC.
  task automatic checkOutput(input int hold, input logic clr);
    exp_t e;
    int   n;
    bus.sticky_clr = clr;
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    bus.sticky_clr = 1'b0;
    check("rsp_latency", n, 2);
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
      e = '0;
    end else begin
      e = sb_q.pop_front();
    end
    sticky_m = (clr ? 5'b0 : sticky_m) | e.flags;
    check("rsp_data", bus.rsp_data, e.data);
    check("rsp_rd", bus.rsp_rd, e.rd);
    check("rsp_flags", bus.rsp_flags, e.flags);
    check("sticky", bus.sticky_flags, sticky_m);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_rsp", {bus.rsp_valid, bus.rsp_data, bus.rsp_rd, bus.rsp_flags},
            {1'b1, e.data, e.rd, e.flags});
      check("hold_cmd_ready", bus.cmd_ready, 1'b0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    check("rsp_released", bus.rsp_valid, 1'b0);
  endtask

  task automatic pulseClear();
    bus.sticky_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.sticky_clr = 1'b0;
    sticky_m = '0;
    check("sticky_idle_clr", bus.sticky_flags, 5'b0);
  endtask

  initial begin
    checks = 0;
    passes = 0;
    resetModel();
    rst_n           = 1'b0;
    bus.cmd_valid   = 1'b0;
    bus.cmd_op      = '0;
    bus.cmd_rd      = '0;
    bus.cmd_ra      = '0;
    bus.cmd_rb      = '0;
    bus.cmd_a_zero  = 1'b0;
    bus.cmd_use_imm = 1'b0;
    bus.cmd_imm     = '0;
    bus.rsp_ready   = 1'b0;
    bus.sticky_clr  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_ready_valid", {bus.cmd_ready, bus.rsp_valid}, 2'b10);
    check("reset_rsp", {bus.rsp_data, bus.rsp_rd, bus.rsp_flags, bus.sticky_flags}, '0);
    check("reset_alu", {bus.alu_a, bus.alu_b, bus.alu_sel}, '0);

    $display("[TB] load immediate");
    applyStimulus(OP_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 1'b1, 8'h0F);
    waitAccept();
    check("ready_low_exec", bus.cmd_ready, 1'b0);
    checkOutput(0, 1'b0);

    $display("[TB] carry and zero with sticky");
    applyStimulus(OP_ADD, 2'd2, 2'd0, 2'd0, 1'b1, 1'b1, 8'hFF);
    waitAccept();
    checkOutput(0, 1'b0);
    pulseClear();
    applyStimulus(OP_ADD, 2'd3, 2'd2, 2'd0, 1'b0, 1'b1, 8'h01);
    waitAccept();
    checkOutput(0, 1'b0);
    applyStimulus(OP_ADD, 2'd0, 2'd0, 2'd0, 1'b1, 1'b1, 8'h05);
    waitAccept();
    checkOutput(0, 1'b0);

    $display("[TB] backpressure with pending command");
    applyStimulus(OP_ADD, 2'd0, 2'd0, 2'd0, 1'b1, 1'b1, 8'h33);
    waitAccept();
    applyStimulus(OP_ADD, 2'd2, 2'd0, 2'd1, 1'b0, 1'b0, 8'h00);
    checkOutput(5, 1'b0);
    @(negedge clk);
    check("ready_after_rsp", bus.cmd_ready, 1'b1);
    waitAccept();
    checkOutput(0, 1'b0);

    $display("[TB] back-to-back write-back");
    applyStimulus(OP_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 1'b1, 8'h0F);
    waitAccept();
    checkOutput(0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(OP_SUB, 2'd1, 2'd1, 2'd0, 1'b0, 1'b1, 8'h01);
      waitAccept();
      checkOutput(0, 1'b0);
    end

    $display("[TB] reset during EXEC");
    applyStimulus(OP_ADD, 2'd0, 2'd0, 2'd0, 1'b1, 1'b1, 8'h55);
    waitAccept();
    rst_n = 1'b0;
    #1;
    check("async_rst_rsp", {bus.rsp_valid, bus.rsp_data, bus.rsp_rd, bus.rsp_flags, bus.sticky_flags}, '0);
    check("async_rst_alu", {bus.alu_a, bus.alu_b, bus.alu_sel}, '0);
    resetModel();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_rsp_after_rst", bus.rsp_valid, 1'b0);
    end
    for (int r = 0; r < NREG; r++) begin
      applyStimulus(OP_ADD, RAW'(r), RAW'(r), 2'd0, 1'b0, 1'b1, 8'h00);
      waitAccept();
      checkOutput(0, 1'b0);
    end

    $display("[TB] sticky clear during capture");
    applyStimulus(OP_ADD, 2'd0, 2'd0, 2'd0, 1'b1, 1'b1, 8'h7F);
    waitAccept();
    checkOutput(0, 1'b0);
    applyStimulus(OP_ADD, 2'd1, 2'd2, 2'd0, 1'b1, 1'b1, 8'hFF);
    waitAccept();
    checkOutput(0, 1'b0);
    applyStimulus(OP_ADD, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 8'h01);
    waitAccept();
    checkOutput(0, 1'b1);
    check("sticky_ovf_neg", bus.sticky_flags, 5'b01100);
    pulseClear();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
